// File: rtl/median_block_averager_if.sv
// Handshake bundle between the median filter, the block averager and the readout consumer.
// Carries the sample strobe/data inward and the averaged result, valid/ready and status outward.
// master = filter/readout side that drives samples and ready; slave = the averager.
interface median_block_averager_if #(
   parameter int DATA_W = 16,
   parameter int LOG2_N = 3
);
   logic [DATA_W-1:0] in_data;
   logic              load;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              overrun;
   logic [LOG2_N-1:0] count;

   modport master (
      output in_data, load, out_ready,
      input  out_data, out_valid, overrun, count
   );

   modport slave (
      input  in_data, load, out_ready,
      output out_data, out_valid, overrun, count
   );
endinterface

// File: rtl/median_block_averager.sv
// Averages 2**LOG2_N filtered samples into a one-deep VALID/READY output register (AVG_ROUND_EN: round half up).
// Latency: result valid the cycle after the Nth load; accumulator state updates every load cycle.
// Backpressure: none toward the input; a stalled consumer gets its result overwritten and overrun set.
module median_block_averager #(
   parameter int DATA_W = 16,
   parameter int LOG2_N = 3
) (
   input  logic                 clk,
   input  logic                 hard_reset,
   input  logic                 rst,
   median_block_averager_if.slave bus
);
   localparam int ACC_W = DATA_W + LOG2_N;
   localparam logic [LOG2_N-1:0] LAST = '1;

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

   state_t            state;
   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  sum;
   logic [LOG2_N-1:0] count;
   logic [DATA_W-1:0] out_data;
   logic [DATA_W-1:0] mean;
   logic              overrun;
   logic              complete;

`ifdef AVG_ROUND_EN
   localparam logic [ACC_W:0] HALF = (ACC_W+1)'(1) << (LOG2_N - 1);
`endif

   // Running sum including the current sample, its mean, and the block-completion strobe.
   always_comb begin
      sum      = acc + ACC_W'(bus.in_data);
      complete = bus.load && (count == LAST);
`ifdef AVG_ROUND_EN
      // One extra bit keeps the rounding add exact; the mean of N in-range samples always fits DATA_W.
      mean = DATA_W'(({1'b0, sum} + HALF) >> LOG2_N);
`else
      mean = DATA_W'(sum >> LOG2_N);
`endif
   end

   // Accumulator, sample counter and the two-state output register with sticky overrun.
   always_ff @(posedge clk or posedge hard_reset) begin
      if (hard_reset) begin
         state    <= EMPTY;
         acc      <= '0;
         count    <= '0;
         out_data <= '0;
         overrun  <= 1'b0;
      end else if (rst) begin
         // Frame restart wins over a coincident load; that sample is dropped.
         state    <= EMPTY;
         acc      <= '0;
         count    <= '0;
         out_data <= '0;
         overrun  <= 1'b0;
      end else begin
         if (complete) begin
            acc      <= '0;
            count    <= '0;
            out_data <= mean;
            state    <= FULL;
            // Only a result nobody took this cycle counts as lost.
            if (state == FULL && !bus.out_ready)
               overrun <= 1'b1;
         end else begin
            if (bus.load) begin
               acc   <= sum;
               count <= count + 1'b1;
            end
            if (state == FULL && bus.out_ready)
               state <= EMPTY;
         end
      end
   end

   assign bus.out_data  = out_data;
   assign bus.out_valid = (state == FULL);
   assign bus.overrun   = overrun;
   assign bus.count     = count;
endmodule

// File: tb/tb_median_block_averager.sv
// Directed bench for median_block_averager with hand-computed expected results.
// Inputs change 1 ns after each rising edge; outputs are sampled there too.
// Build with +define+AVG_ROUND_EN to check the rounding variant.
module tb_median_block_averager;
   logic clk;
   logic hard_reset;
   logic rst;
   int   n_checks;
   int   n_pass;

   median_block_averager_if #(.DATA_W(16), .LOG2_N(3)) bus ();

   median_block_averager #(.DATA_W(16), .LOG2_N(3)) dut (
      .clk        (clk),
      .hard_reset (hard_reset),
      .rst        (rst),
      .bus        (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] v);
      bus.load    = 1'b1;
      bus.in_data = v;
      tick();
      bus.load    = 1'b0;
   endtask

   task automatic consume();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   logic [15:0] exp_mean_100;

   initial begin
      n_checks      = 0;
      n_pass        = 0;
`ifdef AVG_ROUND_EN
      exp_mean_100  = 16'd104;
`else
      exp_mean_100  = 16'd103;
`endif
      hard_reset    = 1'b1;
      rst           = 1'b0;
      bus.load      = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;
      #2;
      check("reset_valid",   32'(bus.out_valid), 32'd0);
      check("reset_data",    32'(bus.out_data),  32'd0);
      check("reset_count",   32'(bus.count),     32'd0);
      check("reset_overrun", 32'(bus.overrun),   32'd0);
      tick();
      hard_reset = 1'b0;
      tick();

      // 100..107 with consumer stalled: mean 103.5
      for (int i = 0; i < 7; i++) push(16'(100 + i));
      check("mean100_count7", 32'(bus.count),     32'd7);
      check("mean100_early",  32'(bus.out_valid), 32'd0);
      push(16'd107);
      check("mean100_valid",  32'(bus.out_valid), 32'd1);
      check("mean100_data",   32'(bus.out_data),  32'(exp_mean_100));
      check("mean100_count0", 32'(bus.count),     32'd0);

      // Hard reset mid-block after 3 loads, with a load held during reset
      for (int i = 0; i < 3; i++) push(16'd900);
      check("pre_hr_count", 32'(bus.count), 32'd3);
      hard_reset  = 1'b1;
      #1;
      check("hr_valid",   32'(bus.out_valid), 32'd0);
      check("hr_data",    32'(bus.out_data),  32'd0);
      check("hr_count",   32'(bus.count),     32'd0);
      bus.load    = 1'b1;
      bus.in_data = 16'd500;
      tick();
      bus.load    = 1'b0;
      hard_reset  = 1'b0;
      check("hr_load_ignored", 32'(bus.count), 32'd0);
      for (int i = 0; i < 8; i++) push(16'd40);
      check("fresh_valid", 32'(bus.out_valid), 32'd1);
      check("fresh_data",  32'(bus.out_data),  32'd40);

      // Handshake drains the register
      consume();
      check("drain_valid", 32'(bus.out_valid), 32'd0);
      consume();
      check("ready_empty_ignored", 32'(bus.out_valid), 32'd0);

      // Full-scale samples must not overflow
      for (int i = 0; i < 8; i++) push(16'hFFFF);
      check("max_data",    32'(bus.out_data), 32'h0000FFFF);
      check("max_overrun", 32'(bus.overrun),  32'd0);
      consume();

      // Stalled consumer: second result overwrites, overrun sticks
      for (int i = 0; i < 8; i++) push(16'd10);
      check("ovr_first_data", 32'(bus.out_data), 32'd10);
      check("ovr_first_flag", 32'(bus.overrun),  32'd0);
      for (int i = 0; i < 8; i++) push(16'd20);
      check("ovr_data",  32'(bus.out_data),  32'd20);
      check("ovr_flag",  32'(bus.overrun),   32'd1);
      check("ovr_valid", 32'(bus.out_valid), 32'd1);
      consume();
      check("ovr_sticky", 32'(bus.overrun),   32'd1);
      check("ovr_drain",  32'(bus.out_valid), 32'd0);

      // Soft clear together with the 5th load drops that sample
      for (int i = 0; i < 4; i++) push(16'd7);
      rst         = 1'b1;
      bus.load    = 1'b1;
      bus.in_data = 16'd7;
      tick();
      rst         = 1'b0;
      bus.load    = 1'b0;
      check("rst_count",   32'(bus.count),   32'd0);
      check("rst_overrun", 32'(bus.overrun), 32'd0);
      for (int i = 0; i < 8; i++) push(16'd50);
      check("rst_block_data", 32'(bus.out_data), 32'd50);

      // Ready coincides with the next completion: new result, still full, no overrun
      for (int i = 0; i < 7; i++) push(16'd60);
      bus.out_ready = 1'b1;
      push(16'd60);
      bus.out_ready = 1'b0;
      check("coinc_valid",   32'(bus.out_valid), 32'd1);
      check("coinc_data",    32'(bus.out_data),  32'd60);
      check("coinc_overrun", 32'(bus.overrun),   32'd0);
      tick();
      check("coinc_hold", 32'(bus.out_valid), 32'd1);
      consume();
      check("coinc_drain", 32'(bus.out_valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
